// File: rtl/aes_pkg.sv
// Shared AES constants: FIPS-197 S-box, state-block geometry, SubBytes FSM states.
package aes_pkg;

  localparam int unsigned AES_NUM_BYTES = 16;
  localparam int unsigned AES_BYTE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sb_state_e;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Byte 0 is the most significant byte of the 128-bit state.
  function automatic logic [6:0] byte_msb(input logic [3:0] k);
    return 7'd127 - {k, 3'b000};
  endfunction

endpackage

// File: rtl/aes_sbox_lut.sv
// Registered 256x8 AES S-box lookup, one cycle of latency.
module aes_sbox_lut
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  output logic [7:0] data
);

  always_ff @(posedge clk) begin
    data <= AES_SBOX[addr];
  end

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// AES SubBytes over a 128-bit state: bytes are streamed one per cycle through a
// registered S-box and reassembled into the output block.
module aes_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned NUM_BYTES = AES_NUM_BYTES,
  parameter int unsigned BYTE_W    = AES_BYTE_W
)
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_BYTES*BYTE_W-1:0] in_state,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_BYTES*BYTE_W-1:0] out_state,
  output logic                        busy
);

  localparam int unsigned STATE_W  = NUM_BYTES * BYTE_W;
  localparam logic [3:0]  LAST_IDX = 4'(NUM_BYTES - 1);

  sb_state_e          state_q, state_d;
  logic [3:0]         issue_cnt_q, issue_cnt_d;
  logic [3:0]         cap_cnt_q;
  logic               cap_vld_q;
  logic [STATE_W-1:0] src_q, src_d;
  logic [STATE_W-1:0] out_state_q, out_state_d;
  logic [BYTE_W-1:0]  lut_addr;
  logic [BYTE_W-1:0]  lut_data;

  assign lut_addr = src_q[byte_msb(issue_cnt_q) -: BYTE_W];

  aes_sbox_lut u_sbox (
    .clk  (clk),
    .addr (lut_addr),
    .data (lut_data)
  );

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    src_d       = src_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          src_d       = in_state;
          issue_cnt_d = '0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        issue_cnt_d = issue_cnt_q + 4'd1;
        if (issue_cnt_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // LUT data lags its address by one cycle, so capture follows issue via cap_cnt/cap_vld;
  // the DRAIN cycle is simply the capture of the final issued byte.
  always_comb begin
    out_state_d = out_state_q;
    if (cap_vld_q) begin
      out_state_d[byte_msb(cap_cnt_q) -: BYTE_W] = lut_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      cap_vld_q   <= 1'b0;
      src_q       <= '0;
      out_state_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= issue_cnt_q;
      cap_vld_q   <= (state_q == ST_RUN);
      src_q       <= src_d;
      out_state_q <= out_state_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_state = out_state_q;

endmodule
